block_sync_ctrl: RTL and testbench
==================================

# block_sync_ctrl

Controls 64b/66b block alignment for the RX recovery path. It watches the 2-bit sync header of every 66-bit word leaving `gearbox32to66` and drives that gearbox's `slip_i` until word boundaries are found. Once aligned it keeps monitoring and reports lock. It then re-enters hunting when header errors exceed a threshold inside a monitoring window.

## Interface
- `LOCK_CNT`, default 64: consecutive valid headers needed to declare lock.
- `UNLOCK_CNT`, default 16: invalid headers within one window that force lock loss.
- `WINDOW`, default 1024: length of the monitoring window in LOCKED, counted in valid words.
- `SLIP_WAIT`, default 4: valid words ignored after each slip while the gearbox pipeline flushes.
- `clk_i` input 1: RX clock, the same clock as the gearbox.
- `rst_ni` input 1: reset, asynchronous, active-low.
- `enable_i` input 1: alignment enable. When low, the FSM is forced to HUNT and no slips are issued.
- `data66_valid_i` input 1: gearbox `data66_valid_o`.
- `header_i` input 2: sync header bits of the current gearbox output word, i.e. `data66_o[65:64]`.
- `slip_o` output 1: one-cycle slip pulse to gearbox `slip_i`. Each pulse shifts the gearbox by one bit.
- `locked_o` output 1: block lock status.
- `slip_count_o` output 16: total slips since reset. Saturates at 16'hFFFF.
- `lock_loss_o` output 1: one-cycle pulse when LOCKED exits due to errors.

## Operation
- Header validity: 2'b01 and 2'b10 are valid; 2'b00 and 2'b11 are invalid.
- Headers are evaluated only in cycles where `data66_valid_i`=1. All other cycles leave counters unchanged.
- State machine, encoded as HUNT, SLIP, WAIT, LOCKED:
  - HUNT: a valid header increments `good_cnt`. When `good_cnt` reaches `LOCK_CNT` → LOCKED, clear counters. An invalid header → SLIP, clear `good_cnt`.
  - SLIP: occupies exactly one cycle with `slip_o`=1. Increments `slip_count_o` (saturating). → WAIT.
  - WAIT: counts `SLIP_WAIT` valid words and ignores their headers. After the `SLIP_WAIT`-th valid word → HUNT.
  - LOCKED: `locked_o`=1. Each valid word increments `win_cnt`; each invalid header increments `bad_cnt`.
    - If `bad_cnt` reaches `UNLOCK_CNT` → SLIP, with `lock_loss_o` pulsed in the same cycle as the transition.
    - Otherwise, on the `WINDOW`-th valid word, both `win_cnt` and `bad_cnt` clear and the FSM stays LOCKED.
    - If the `UNLOCK_CNT`-th bad header lands on the `WINDOW`-th word, the unlock wins.
- `enable_i`=0 has priority over every transition:
  - next state is HUNT and all counters clear except `slip_count_o`;
  - `slip_o` and `lock_loss_o` are forced to 0.
  - Deasserting `enable_i` while LOCKED does not pulse `lock_loss_o`.
- Counter widths are `$clog2(param+1)`. Counters never wrap.

## Timing
- All outputs are registered.
- Reset values: state HUNT, `slip_o`=0, `locked_o`=0, `slip_count_o`=0, `lock_loss_o`=0, all internal counters 0.
- An invalid header sampled in HUNT at edge N produces `slip_o`=1 during cycle N+1 only.
- The gearbox applies the slip at edge N+2. The first evaluated header after that is the (`SLIP_WAIT`+1)-th valid word after the slip.
- `locked_o` rises in the cycle after the `LOCK_CNT`-th consecutive valid header is sampled.
- On lock loss, `locked_o` falls in the same cycle that `slip_o` and `lock_loss_o` rise.
- Back-to-back valid words (valid held high) are supported. Sparse valid (e.g. 1 in 8 cycles) behaves identically when counted in words.
- Reset asserted mid-operation (any state) returns all outputs to reset values asynchronously. A slip pulse in flight is truncated.

## Test plan
All scenarios use default parameters.
- **Reset:** hold `rst_ni`=0 with random `header_i`/valid. Required: `slip_o`=0, `locked_o`=0, `slip_count_o`=0 throughout. After release, the FSM is in HUNT.
- **Clean lock:** 64 valid words with header 2'b01. Required: `locked_o` rises the cycle after the 64th; no `slip_o` pulse. After 63 words, `locked_o` must still be 0.
- **Slip and wait:**
  - In HUNT, valid word #10 carries header 2'b11. Required: single-cycle `slip_o`, `slip_count_o`=1.
  - The next 4 valid words carry 2'b00. Required: no further slip.
  - Word #5 after the slip carries 2'b00. Required: second slip, `slip_count_o`=2.
- **Lock loss threshold:**
  - LOCKED, 15 invalid headers within 1024 words. Required: stays locked.
  - 16th invalid header within the same window. Required: `locked_o`→0, `slip_o` and `lock_loss_o` pulse together.
- **Window reset:** LOCKED, 15 bad headers in window 1, then 15 bad in window 2. Required: remains locked, no slip.
- **Integration with `gearbox32to66`:** feed 32-bit words built from 66-bit blocks with header 2'b01 at an arbitrary phase; enable, run ≥66×(4+1) words. Required:
  - `locked_o`=1 eventually;
  - `data66_o[65:64]`=2'b01 on every valid word thereafter;
  - `slip_count_o` ≤ 65.

Source files
------------

// File: rtl/block_sync_ctrl.sv
// 64b/66b block alignment controller: hunts for sync-header lock by slipping the
// RX gearbox one bit at a time, then monitors header errors per window once locked.
module block_sync_ctrl #(
   parameter int LOCK_CNT   = 64,
   parameter int UNLOCK_CNT = 16,
   parameter int WINDOW     = 1024,
   parameter int SLIP_WAIT  = 4
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        enable_i,
   input  logic        data66_valid_i,
   input  logic [1:0]  header_i,
   output logic        slip_o,
   output logic        locked_o,
   output logic [15:0] slip_count_o,
   output logic        lock_loss_o
);

   localparam int GW = $clog2(LOCK_CNT + 1);
   localparam int BW = $clog2(UNLOCK_CNT + 1);
   localparam int NW = $clog2(WINDOW + 1);
   localparam int WW = $clog2(SLIP_WAIT + 1);

   typedef enum logic [1:0] {HUNT, SLIP, WAIT, LOCKED} state_t;

   state_t        state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [BW-1:0] bad_q, bad_d;
   logic [NW-1:0] win_q, win_d;
   logic [WW-1:0] wait_q, wait_d;
   logic          slip_d, loss_d;
   logic          hdr_ok;

   assign hdr_ok = header_i[1] ^ header_i[0];

   always_comb begin
      state_d = state_q;
      good_d  = good_q;
      bad_d   = bad_q;
      win_d   = win_q;
      wait_d  = wait_q;
      slip_d  = 1'b0;
      loss_d  = 1'b0;

      case (state_q)
         HUNT: begin
            if (data66_valid_i) begin
               if (!hdr_ok) begin
                  state_d = SLIP;
                  good_d  = '0;
                  slip_d  = 1'b1;
               end else if (good_q == GW'(LOCK_CNT - 1)) begin
                  state_d = LOCKED;
                  good_d  = '0;
                  bad_d   = '0;
                  win_d   = '0;
               end else begin
                  good_d = good_q + GW'(1);
               end
            end
         end
         SLIP: begin
            state_d = WAIT;
            wait_d  = '0;
         end
         WAIT: begin
            if (data66_valid_i) begin
               if (wait_q == WW'(SLIP_WAIT - 1)) begin
                  state_d = HUNT;
                  wait_d  = '0;
               end else begin
                  wait_d = wait_q + WW'(1);
               end
            end
         end
         LOCKED: begin
            // the unlock check comes first so a threshold hit on the last word of a window still unlocks
            if (data66_valid_i) begin
               if (!hdr_ok && (bad_q == BW'(UNLOCK_CNT - 1))) begin
                  state_d = SLIP;
                  slip_d  = 1'b1;
                  loss_d  = 1'b1;
                  bad_d   = '0;
                  win_d   = '0;
               end else if (win_q == NW'(WINDOW - 1)) begin
                  bad_d = '0;
                  win_d = '0;
               end else begin
                  win_d = win_q + NW'(1);
                  bad_d = bad_q + BW'(!hdr_ok);
               end
            end
         end
         default: state_d = HUNT;
      endcase

      if (!enable_i) begin
         state_d = HUNT;
         good_d  = '0;
         bad_d   = '0;
         win_d   = '0;
         wait_d  = '0;
         slip_d  = 1'b0;
         loss_d  = 1'b0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= HUNT;
         good_q       <= '0;
         bad_q        <= '0;
         win_q        <= '0;
         wait_q       <= '0;
         slip_o       <= 1'b0;
         locked_o     <= 1'b0;
         lock_loss_o  <= 1'b0;
         slip_count_o <= '0;
      end else begin
         state_q     <= state_d;
         good_q      <= good_d;
         bad_q       <= bad_d;
         win_q       <= win_d;
         wait_q      <= wait_d;
         slip_o      <= slip_d;
         locked_o    <= (state_d == LOCKED);
         lock_loss_o <= loss_d;
         if (slip_d && (slip_count_o != 16'hFFFF)) begin
            slip_count_o <= slip_count_o + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_block_sync_ctrl.sv
// Self-checking bench for block_sync_ctrl: directed scenarios plus randomized words
// checked against a word-level reference model and a bit-level gearbox model.
module tb_block_sync_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        enable_i;
   logic        data66_valid_i;
   logic [1:0]  header_i;
   logic        slip_o;
   logic        locked_o;
   logic [15:0] slip_count_o;
   logic        lock_loss_o;

   int vectors = 0;
   int miscompares = 0;

   // word-level reference model state (mode: 0 hunting, 1 waiting after slip, 2 locked)
   int m_mode, m_good, m_skip, m_bad, m_win, m_slips;
   bit m_slip, m_loss;

   logic        obs_slip, obs_loss, obs_locked, obs2_slip, obs2_loss;
   logic [15:0] obs_count;
   bit          bad_mask [0:1023];
   bit          stream [0:99999];

   block_sync_ctrl dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .enable_i       (enable_i),
      .data66_valid_i (data66_valid_i),
      .header_i       (header_i),
      .slip_o         (slip_o),
      .locked_o       (locked_o),
      .slip_count_o   (slip_count_o),
      .lock_loss_o    (lock_loss_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [1:0] good_hdr();
      return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [1:0] bad_hdr();
      return ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
   endfunction

   function void model_disable();
      m_mode = 0; m_good = 0; m_skip = 0; m_bad = 0; m_win = 0;
      m_slip = 0; m_loss = 0;
   endfunction

   function void model_slip();
      m_slip = 1;
      if (m_slips < 65535) m_slips++;
      m_mode = 1;
      m_skip = 4;
   endfunction

   function void model_word(input logic [1:0] h);
      bit ok;
      ok = (h == 2'b01) || (h == 2'b10);
      m_slip = 0;
      m_loss = 0;
      case (m_mode)
         0: begin
            if (ok) begin
               m_good++;
               if (m_good == 64) begin
                  m_mode = 2; m_good = 0; m_bad = 0; m_win = 0;
               end
            end else begin
               m_good = 0;
               model_slip();
            end
         end
         1: begin
            m_skip--;
            if (m_skip == 0) m_mode = 0;
         end
         default: begin
            m_win++;
            if (!ok) m_bad++;
            if (m_bad == 16) begin
               m_loss = 1; m_bad = 0; m_win = 0;
               model_slip();
            end else if (m_win == 1024) begin
               m_win = 0; m_bad = 0;
            end
         end
      endcase
   endfunction

   task automatic reset_dut();
      rst_ni = 1'b0;
      enable_i = 1'b1;
      data66_valid_i = 1'b0;
      header_i = 2'b00;
      model_disable();
      m_slips = 0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   // one valid word followed by at least one idle cycle; captures outputs after each edge
   task automatic drive_word(input logic [1:0] h, input int gap);
      @(negedge clk_i);
      data66_valid_i = 1'b1;
      header_i = h;
      @(posedge clk_i);
      #1;
      if (enable_i) model_word(h);
      else model_disable();
      obs_slip = slip_o; obs_loss = lock_loss_o; obs_locked = locked_o; obs_count = slip_count_o;
      @(negedge clk_i);
      data66_valid_i = 1'b0;
      header_i = 2'($urandom);
      @(posedge clk_i);
      #1;
      obs2_slip = slip_o; obs2_loss = lock_loss_o;
      repeat (gap) @(posedge clk_i);
   endtask

   task automatic pick_bad(input int n, input int span);
      int cnt = 0;
      for (int i = 0; i < 1024; i++) bad_mask[i] = 0;
      while (cnt < n) begin
         int p = $urandom_range(0, span - 1);
         if (!bad_mask[p]) begin
            bad_mask[p] = 1;
            cnt++;
         end
      end
   endtask

   task automatic lock_up();
      for (int i = 0; i < 64; i++) drive_word(good_hdr(), 0);
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk_i);
         enable_i = 1'($urandom);
         data66_valid_i = 1'($urandom);
         header_i = 2'($urandom);
         @(posedge clk_i);
         #1;
         vectors++;
         if ({slip_o, locked_o, lock_loss_o, slip_count_o} !== 19'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_hold: got slip=%b locked=%b loss=%b count=%0d, want all 0",
                     slip_o, locked_o, lock_loss_o, slip_count_o);
         end
      end
      @(negedge clk_i);
      data66_valid_i = 1'b0;
      enable_i = 1'b1;
      rst_ni = 1'b1;
      model_disable();
      m_slips = 0;
      drive_word(2'b11, 0);
      vectors++;
      if (obs_slip !== 1'b1 || obs_count !== 16'd1) begin
         miscompares++;
         $display("[TB] FAIL reset_hunt: got slip=%b count=%0d, want slip=1 count=1", obs_slip, obs_count);
      end
   endtask

   task automatic test_clean_lock();
      bit slip_seen = 0;
      reset_dut();
      for (int i = 1; i <= 64; i++) begin
         @(negedge clk_i);
         data66_valid_i = 1'b1;
         header_i = 2'b01;
         @(posedge clk_i);
         #1;
         if (slip_o) slip_seen = 1;
         if (i == 63) begin
            vectors++;
            if (locked_o !== 1'b0) begin
               miscompares++;
               $display("[TB] FAIL lock_early: got locked=%b after 63 words, want 0", locked_o);
            end
         end
      end
      vectors++;
      if (locked_o !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL lock_rise: got locked=%b after 64 words, want 1", locked_o);
      end
      @(negedge clk_i);
      data66_valid_i = 1'b0;
      vectors++;
      if (slip_seen || slip_count_o !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL lock_noslip: got slip_seen=%b count=%0d, want 0 and 0", slip_seen, slip_count_o);
      end
   endtask

   task automatic test_slip_wait();
      bit extra = 0;
      reset_dut();
      for (int i = 1; i <= 9; i++) drive_word(2'b01, 0);
      drive_word(2'b11, 0);
      vectors++;
      if (obs_slip !== 1'b1 || obs2_slip !== 1'b0 || obs_count !== 16'd1) begin
         miscompares++;
         $display("[TB] FAIL slip_first: got pulse=%b next=%b count=%0d, want 1 0 1", obs_slip, obs2_slip, obs_count);
      end
      for (int i = 0; i < 4; i++) begin
         drive_word(2'b00, $urandom_range(0, 3));
         if (obs_slip || obs2_slip) extra = 1;
      end
      vectors++;
      if (extra || slip_count_o !== 16'd1) begin
         miscompares++;
         $display("[TB] FAIL slip_wait: got extra_slip=%b count=%0d, want 0 and 1", extra, slip_count_o);
      end
      drive_word(2'b00, 0);
      vectors++;
      if (obs_slip !== 1'b1 || obs_count !== 16'd2) begin
         miscompares++;
         $display("[TB] FAIL slip_second: got slip=%b count=%0d, want 1 2", obs_slip, obs_count);
      end
   endtask

   task automatic test_lock_threshold();
      bit lost = 0;
      reset_dut();
      lock_up();
      pick_bad(15, 1000);
      for (int i = 0; i < 1000; i++) begin
         drive_word(bad_mask[i] ? bad_hdr() : good_hdr(), 0);
         if (!obs_locked || obs_slip || obs_loss) lost = 1;
      end
      vectors++;
      if (lost) begin
         miscompares++;
         $display("[TB] FAIL thresh_15: got lock dropped or slip, want locked throughout");
      end
      drive_word(bad_hdr(), 0);
      vectors++;
      if (obs_locked !== 1'b0 || obs_slip !== 1'b1 || obs_loss !== 1'b1 || obs2_loss !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL thresh_16: got locked=%b slip=%b loss=%b loss_next=%b, want 0 1 1 0",
                  obs_locked, obs_slip, obs_loss, obs2_loss);
      end
   endtask

   task automatic test_window_reset();
      bit lost = 0;
      reset_dut();
      lock_up();
      for (int w = 0; w < 2; w++) begin
         pick_bad(15, 1024);
         for (int i = 0; i < 1024; i++) begin
            drive_word(bad_mask[i] ? bad_hdr() : good_hdr(), 0);
            if (!obs_locked || obs_slip || obs_loss) lost = 1;
         end
      end
      vectors++;
      if (lost || slip_count_o !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL window_keep: got lost=%b count=%0d, want 0 and 0", lost, slip_count_o);
      end
      pick_bad(15, 1023);
      for (int i = 0; i < 1023; i++) drive_word(bad_mask[i] ? bad_hdr() : good_hdr(), 0);
      drive_word(bad_hdr(), 0);
      vectors++;
      if (obs_loss !== 1'b1 || obs_locked !== 1'b0 || obs_slip !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL window_edge: got loss=%b locked=%b slip=%b, want 1 0 1", obs_loss, obs_locked, obs_slip);
      end
   endtask

   task automatic test_enable();
      reset_dut();
      lock_up();
      @(negedge clk_i);
      enable_i = 1'b0;
      @(posedge clk_i);
      #1;
      model_disable();
      vectors++;
      if (locked_o !== 1'b0 || lock_loss_o !== 1'b0 || slip_o !== 1'b0) begin
         miscompares++;
         $display("[TB] FAIL enable_drop: got locked=%b loss=%b slip=%b, want 0 0 0", locked_o, lock_loss_o, slip_o);
      end
      drive_word(2'b11, 0);
      vectors++;
      if (obs_slip !== 1'b0 || obs_count !== 16'd0) begin
         miscompares++;
         $display("[TB] FAIL enable_noslip: got slip=%b count=%0d, want 0 0", obs_slip, obs_count);
      end
      @(negedge clk_i);
      enable_i = 1'b1;
      for (int i = 0; i < 63; i++) drive_word(2'b10, 0);
      drive_word(2'b01, 0);
      vectors++;
      if (obs_locked !== 1'b1) begin
         miscompares++;
         $display("[TB] FAIL enable_relock: got locked=%b after 64 words, want 1", obs_locked);
      end
   endtask

   task automatic test_random();
      reset_dut();
      for (int i = 0; i < 1500; i++) begin
         logic [1:0] h = ($urandom_range(0, 49) == 0) ? bad_hdr() : good_hdr();
         drive_word(h, $urandom_range(0, 2));
         vectors++;
         if ({obs_slip, obs_loss, obs_locked, obs_count} !== {m_slip, m_loss, (m_mode == 2), 16'(m_slips)}) begin
            miscompares++;
            $display("[TB] FAIL random_word%0d: got slip=%b loss=%b locked=%b count=%0d, want %b %b %b %0d",
                     i, obs_slip, obs_loss, obs_locked, obs_count, m_slip, m_loss, (m_mode == 2), m_slips);
         end
         vectors++;
         if (obs2_slip !== 1'b0 || obs2_loss !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL random_pulse%0d: got slip=%b loss=%b one cycle later, want 0 0", i, obs2_slip, obs2_loss);
         end
      end
   endtask

   // bit-level gearbox: each valid word starts 66 bits after the previous, a slip adds one bit
   task automatic test_integration();
      int phase, base, exp_slips, after;
      bit seen = 0;
      bit bad_after = 0;
      reset_dut();
      for (int b = 0; b < 1515; b++) begin
         for (int k = 0; k < 66; k++) stream[66 * b + k] = 1'($urandom);
         stream[66 * b] = 1'b0;
         stream[66 * b + 1] = 1'b1;
      end
      phase = $urandom_range(0, 65);
      base = phase;
      exp_slips = (66 - phase) % 66;
      after = 0;
      for (int w = 0; w < 1400 && after < 200; w++) begin
         @(negedge clk_i);
         if (slip_o) base++;
         header_i = {stream[base], stream[base + 1]};
         data66_valid_i = 1'b1;
         base += 66;
         if (seen) begin
            after++;
            if (header_i !== 2'b01 || !locked_o) bad_after = 1;
         end
         @(posedge clk_i);
         #1;
         if (locked_o) seen = 1;
      end
      @(negedge clk_i);
      data66_valid_i = 1'b0;
      vectors++;
      if (!seen || after < 200) begin
         miscompares++;
         $display("[TB] FAIL integ_lock: got locked=%b words_after=%0d within budget, want lock and 200 words", seen, after);
      end
      vectors++;
      if (bad_after) begin
         miscompares++;
         $display("[TB] FAIL integ_header: got misaligned header or lock drop after lock, want 2'b01 every word");
      end
      vectors++;
      if (slip_count_o !== 16'(exp_slips) || slip_count_o > 16'd65) begin
         miscompares++;
         $display("[TB] FAIL integ_slips: got %0d slips for phase %0d, want %0d", slip_count_o, phase, exp_slips);
      end
   endtask

   initial begin
      rst_ni = 1'b0;
      enable_i = 1'b1;
      data66_valid_i = 1'b0;
      header_i = 2'b00;
      model_disable();
      m_slips = 0;
      test_reset();
      test_clean_lock();
      test_slip_wait();
      test_lock_threshold();
      test_window_reset();
      test_enable();
      test_random();
      test_integration();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "[TB] watchdog");
   end

endmodule
